// File: rtl/rtc_boot_pkg.sv
// Shared definitions for the RTC boot sequencer: register map, config bits,
// FSM/error encodings and the per-step transfer table.
package rtc_boot_pkg;

    localparam logic [7:0] REG_CONFIG     = 8'h00;
    localparam logic [7:0] REG_ENABLE     = 8'h04;
    localparam logic [7:0] REG_CONST      = 8'h08;
    localparam logic [7:0] REG_INIT_SEC   = 8'h0C;
    localparam logic [7:0] REG_INIT_MIN   = 8'h10;
    localparam logic [7:0] REG_INIT_HOURS = 8'h14;
    localparam logic [7:0] REG_INIT_DOW   = 8'h18;
    localparam logic [7:0] REG_INIT_DOM   = 8'h1C;
    localparam logic [7:0] REG_INIT_MONTH = 8'h20;
    localparam logic [7:0] REG_INIT_YEAR  = 8'h24;

    localparam int CFG_GEN_EN_BIT    = 0;
    localparam int CFG_SEL_CLK_BIT   = 1;
    localparam int CFG_SEL_MODE_BIT  = 2;
    localparam int CFG_EN_PRESET_BIT = 3;

    localparam int                STEP_W          = 5;
    localparam logic [STEP_W-1:0] LAST_WRITE_STEP = 5'd10;
    localparam logic [STEP_W-1:0] FIRST_READ_STEP = 5'd11;
    localparam logic [STEP_W-1:0] LAST_READ_STEP  = 5'd19;

    typedef enum logic [2:0] {SEQ_IDLE, SEQ_XFER, SEQ_NEXT, SEQ_DONE, SEQ_ERR} seq_state_e;
    typedef enum logic [1:0] {APB_IDLE, APB_SETUP, APB_ACCESS} apb_state_e;
    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_SLVERR   = 2'd1,
        ERR_TIMEOUT  = 2'd2,
        ERR_READBACK = 2'd3
    } err_code_e;

    typedef struct packed {
        logic [31:0] cnst;
        logic        gen_en;
        logic        sel_clk;
        logic        sel_mode;
        logic [5:0]  sec;
        logic [5:0]  min;
        logic [4:0]  hour;
        logic [1:0]  mode;
        logic [2:0]  dow;
        logic [4:0]  dom;
        logic [3:0]  month;
        logic [11:0] year;
    } boot_fields_t;

    typedef struct packed {
        logic [7:0]  offset;
        logic [31:0] data;
        logic        write;
    } xfer_t;

    function automatic logic [3:0] cfg_word(input boot_fields_t f, input logic en_preset);
        logic [3:0] w;
        w                    = '0;
        w[CFG_GEN_EN_BIT]    = f.gen_en;
        w[CFG_SEL_CLK_BIT]   = f.sel_clk;
        w[CFG_SEL_MODE_BIT]  = f.sel_mode;
        w[CFG_EN_PRESET_BIT] = en_preset;
        return w;
    endfunction

    // Steps 11..19 re-read CONST, the INIT registers and finally CONFIG, so
    // they map back onto write steps 0..7 and 10 for address and expected data.
    function automatic xfer_t step_xfer(input logic [STEP_W-1:0] step, input boot_fields_t f);
        xfer_t             x;
        logic [STEP_W-1:0] idx;
        x.write = (step <= LAST_WRITE_STEP);
        if (step == LAST_READ_STEP)       idx = LAST_WRITE_STEP;
        else if (step > LAST_WRITE_STEP)  idx = step - FIRST_READ_STEP;
        else                              idx = step;
        x.offset = REG_CONFIG;
        x.data   = '0;
        case (idx)
            5'd0: begin x.offset = REG_CONST;      x.data = f.cnst;                    end
            5'd1: begin x.offset = REG_INIT_SEC;   x.data = 32'(f.sec);                end
            5'd2: begin x.offset = REG_INIT_MIN;   x.data = 32'(f.min);                end
            5'd3: begin x.offset = REG_INIT_HOURS; x.data = 32'({f.mode, f.hour});     end
            5'd4: begin x.offset = REG_INIT_DOW;   x.data = 32'(f.dow);                end
            5'd5: begin x.offset = REG_INIT_DOM;   x.data = 32'(f.dom);                end
            5'd6: begin x.offset = REG_INIT_MONTH; x.data = 32'(f.month);              end
            5'd7: begin x.offset = REG_INIT_YEAR;  x.data = 32'(f.year);               end
            5'd8: begin x.offset = REG_CONFIG;     x.data = 32'(cfg_word(f, 1'b1));    end
            5'd9: begin x.offset = REG_ENABLE;     x.data = 32'd1;                     end
            default: begin x.offset = REG_CONFIG;  x.data = 32'(cfg_word(f, 1'b0));    end
        endcase
        return x;
    endfunction

    function automatic logic [31:0] rb_mask(input logic [STEP_W-1:0] step);
        case (step)
            5'd12, 5'd13: return 32'h0000_003F;
            5'd14:        return 32'h0000_007F;
            5'd15:        return 32'h0000_0007;
            5'd16:        return 32'h0000_001F;
            5'd17:        return 32'h0000_000F;
            5'd18:        return 32'h0000_0FFF;
            5'd19:        return 32'h0000_000F;
            default:      return 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/rtc_apb_boot_seq_apb_master_if.sv
// Single APB transfer engine: SETUP, ACCESS with PREADY wait and timeout.
// Address/data/direction are captured on req_i and held for the whole transfer.
module rtc_apb_master_if
    import rtc_boot_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        write_i,
    input  logic        pready_i,
    output logic        psel_o,
    output logic        penable_o,
    output logic        pwrite_o,
    output logic [31:0] paddr_o,
    output logic [31:0] pwdata_o,
    output logic        ack_o,
    output logic        timeout_o
);

    localparam int             CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    apb_state_e       state_q, state_d;
    logic [31:0]      paddr_q, paddr_d, pwdata_q, pwdata_d;
    logic             pwrite_q, pwrite_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d   = state_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pwrite_d  = pwrite_q;
        cnt_d     = cnt_q;
        ack_o     = 1'b0;
        timeout_o = 1'b0;
        case (state_q)
            APB_IDLE: begin
                if (req_i) begin
                    state_d  = APB_SETUP;
                    paddr_d  = addr_i;
                    pwdata_d = wdata_i;
                    pwrite_d = write_i;
                end
            end
            APB_SETUP: begin
                state_d = APB_ACCESS;
                cnt_d   = '0;
            end
            APB_ACCESS: begin
                if (pready_i) begin
                    ack_o   = 1'b1;
                    state_d = APB_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    // This is the TIMEOUT_CYCLES-th ACCESS cycle without PREADY.
                    timeout_o = 1'b1;
                    state_d   = APB_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = APB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= APB_IDLE;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pwrite_q <= pwrite_d;
            cnt_q    <= cnt_d;
        end
    end

    assign psel_o    = (state_q != APB_IDLE);
    assign penable_o = (state_q == APB_ACCESS);
    assign pwrite_o  = pwrite_q;
    assign paddr_o   = paddr_q;
    assign pwdata_o  = pwdata_q;

endmodule

// File: rtl/rtc_apb_boot_seq.sv
// APB boot sequencer that programs the RTC register file after start_i.
// Optional read-back verification of the programmed values: RTC_BOOT_READBACK_EN.
module rtc_apb_boot_seq
    import rtc_boot_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 16,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000
) (
    input  logic        CLK_APB,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] const_i,
    input  logic        gen_en_i,
    input  logic        sel_clk_i,
    input  logic        sel_mode_i,
    input  logic [5:0]  sec_i,
    input  logic [5:0]  min_i,
    input  logic [4:0]  hour_i,
    input  logic [1:0]  mode_i,
    input  logic [2:0]  dow_i,
    input  logic [4:0]  dom_i,
    input  logic [3:0]  month_i,
    input  logic [11:0] year_i,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    input  logic        PREADY,
    input  logic        PSLVERR,
    input  logic [31:0] PRDATA,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [1:0]  err_code_o
);

`ifdef RTC_BOOT_READBACK_EN
    localparam logic [STEP_W-1:0] LAST_STEP = LAST_READ_STEP;
`else
    localparam logic [STEP_W-1:0] LAST_STEP = LAST_WRITE_STEP;
`endif

    seq_state_e        state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    boot_fields_t      shadow_q, shadow_d;
    logic              err_q, err_d;
    err_code_e         err_code_q, err_code_d;

    boot_fields_t      in_fields;
    logic [STEP_W-1:0] req_step;
    xfer_t             req_x;
    logic              req, m_ack, m_timeout, rb_mismatch;

    assign in_fields = '{cnst: const_i, gen_en: gen_en_i, sel_clk: sel_clk_i,
                         sel_mode: sel_mode_i, sec: sec_i, min: min_i, hour: hour_i,
                         mode: mode_i, dow: dow_i, dom: dom_i, month: month_i,
                         year: year_i};

    // A request is issued while leaving IDLE or NEXT, before the step/shadow
    // registers update, so the first step reads the live inputs.
    assign req_step = (state_q == SEQ_IDLE) ? '0 : step_q + 1'b1;
    assign req_x    = step_xfer(req_step, (state_q == SEQ_IDLE) ? in_fields : shadow_q);

`ifdef RTC_BOOT_READBACK_EN
    // PWDATA still holds the expected value loaded for the read step.
    assign rb_mismatch = !PWRITE && (((PRDATA ^ PWDATA) & rb_mask(step_q)) != 32'h0);
`else
    logic unused_prdata;
    assign unused_prdata = ^PRDATA;
    assign rb_mismatch   = 1'b0;
`endif

    rtc_apb_master_if #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_master (
        .clk       (CLK_APB),
        .rst       (rst_i),
        .req_i     (req),
        .addr_i    (BASE_ADDR + 32'(req_x.offset)),
        .wdata_i   (req_x.data),
        .write_i   (req_x.write),
        .pready_i  (PREADY),
        .psel_o    (PSEL),
        .penable_o (PENABLE),
        .pwrite_o  (PWRITE),
        .paddr_o   (PADDR),
        .pwdata_o  (PWDATA),
        .ack_o     (m_ack),
        .timeout_o (m_timeout)
    );

    always_comb begin
        // NOTE: every variable gets a default first, so no branch can leave one
        // unassigned and infer a latch.
        state_d    = state_q;
        step_d     = step_q;
        shadow_d   = shadow_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        req        = 1'b0;
        case (state_q)
            SEQ_IDLE: begin
                if (start_i) begin
                    shadow_d   = in_fields;
                    err_d      = 1'b0;
                    err_code_d = ERR_NONE;
                    step_d     = '0;
                    req        = 1'b1;
                    state_d    = SEQ_XFER;
                end
            end
            SEQ_XFER: begin
                if (m_timeout) begin
                    state_d    = SEQ_ERR;
                    err_d      = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                end else if (m_ack) begin
                    if (PSLVERR) begin
                        state_d    = SEQ_ERR;
                        err_d      = 1'b1;
                        err_code_d = ERR_SLVERR;
                    end else if (rb_mismatch) begin
                        state_d    = SEQ_ERR;
                        err_d      = 1'b1;
                        err_code_d = ERR_READBACK;
                    end else begin
                        state_d = SEQ_NEXT;
                    end
                end
            end
            SEQ_NEXT: begin
                if (step_q == LAST_STEP) begin
                    state_d = SEQ_DONE;
                end else begin
                    step_d  = step_q + 1'b1;
                    req     = 1'b1;
                    state_d = SEQ_XFER;
                end
            end
            SEQ_DONE: state_d = SEQ_IDLE;
            SEQ_ERR:  state_d = SEQ_IDLE;
            default:  state_d = SEQ_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge CLK_APB or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= SEQ_IDLE;
            step_q     <= '0;
            shadow_q   <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            shadow_q   <= shadow_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign busy_o     = (state_q != SEQ_IDLE);
    assign done_o     = (state_q == SEQ_DONE);
    assign err_o      = err_q;
    assign err_code_o = err_code_q;

endmodule

// File: tb/tb_rtc_apb_boot_seq.sv
// Directed bench for rtc_apb_boot_seq with a small APB register-file slave.
// Latencies are counted in clock edges after the edge that samples start_i.
module tb_rtc_apb_boot_seq;

    localparam logic [31:0] BASE = 32'h4000_0000;
`ifdef RTC_BOOT_READBACK_EN
    localparam int DONE_LAT = 60;
    localparam int N_XFER   = 20;
`else
    localparam int DONE_LAT = 33;
    localparam int N_XFER   = 11;
`endif

    logic        CLK_APB = 1'b0;
    logic        rst_i, start_i;
    logic [31:0] const_i;
    logic        gen_en_i, sel_clk_i, sel_mode_i;
    logic [5:0]  sec_i, min_i;
    logic [4:0]  hour_i;
    logic [1:0]  mode_i;
    logic [2:0]  dow_i;
    logic [4:0]  dom_i;
    logic [3:0]  month_i;
    logic [11:0] year_i;
    logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        busy_o, done_o, err_o;
    logic [1:0]  err_code_o;

    rtc_apb_boot_seq #(.TIMEOUT_CYCLES(16), .BASE_ADDR(BASE)) dut (
        .CLK_APB(CLK_APB), .rst_i(rst_i), .start_i(start_i), .const_i(const_i),
        .gen_en_i(gen_en_i), .sel_clk_i(sel_clk_i), .sel_mode_i(sel_mode_i),
        .sec_i(sec_i), .min_i(min_i), .hour_i(hour_i), .mode_i(mode_i),
        .dow_i(dow_i), .dom_i(dom_i), .month_i(month_i), .year_i(year_i),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_code_o(err_code_o)
    );

    always #5 CLK_APB = ~CLK_APB;

    // Slave behaviour knobs, written only by the stimulus block.
    int wait_step = -1;
    int wait_n    = 0;
    int err_step  = -1;
    bit hang      = 1'b0;
    bit corrupt   = 1'b0;

    // Slave state, written only by the slave process.
    int          n_xfer, n_setup, wcnt;
    bit          unstable, done_seen;
    logic [31:0] mem [16];
    logic [31:0] log_addr [32];
    logic [31:0] log_data [32];
    logic        log_wr [32];
    logic [31:0] su_addr, su_data;
    logic        su_wr;

    assign PREADY  = !hang && !(n_xfer == wait_step && wcnt < wait_n);
    assign PSLVERR = PREADY && (n_xfer == err_step);
    assign PRDATA  = mem[PADDR[5:2]] ^ ((corrupt && PADDR[7:0] == 8'h24) ? 32'h1 : 32'h0);

    always @(posedge CLK_APB) begin
        if (rst_i || (start_i && !busy_o)) begin
            n_xfer <= 0; n_setup <= 0; wcnt <= 0; unstable <= 1'b0; done_seen <= 1'b0;
        end else begin
            if (done_o) done_seen <= 1'b1;
            if (PSEL && !PENABLE) begin
                n_setup <= n_setup + 1;
                su_addr <= PADDR; su_data <= PWDATA; su_wr <= PWRITE;
            end
            if (PSEL && PENABLE) begin
                if (PADDR !== su_addr || PWDATA !== su_data || PWRITE !== su_wr) unstable <= 1'b1;
                if (PREADY) begin
                    log_addr[n_xfer] <= PADDR;
                    log_data[n_xfer] <= PWDATA;
                    log_wr[n_xfer]   <= PWRITE;
                    if (PWRITE) mem[PADDR[5:2]] <= PWDATA;
                    n_xfer <= n_xfer + 1;
                    wcnt   <= 0;
                end else begin
                    wcnt <= wcnt + 1;
                end
            end
        end
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK_APB);
        #1;
    endtask

    task automatic do_start();
        start_i = 1'b1;
        tick(1);
        start_i = 1'b0;
    endtask

    task automatic wait_done(output int k);
        k = 0;
        while (!done_o && k < 200) begin tick(1); k++; end
    endtask

    task automatic wait_idle(output int k);
        k = 0;
        while (busy_o && k < 200) begin tick(1); k++; end
    endtask

    task automatic set_fields();
        const_i = 32'd32768; gen_en_i = 1'b1; sel_clk_i = 1'b0; sel_mode_i = 1'b1;
        sec_i = 6'd50; min_i = 6'd59; hour_i = 5'd23; mode_i = 2'b11;
        dow_i = 3'd3; dom_i = 5'd31; month_i = 4'd12; year_i = 12'd2024;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [7:0]  exp_off [11] = '{8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C,
                                  8'h20, 8'h24, 8'h00, 8'h04, 8'h00};
    logic [31:0] exp_dat [11] = '{32'h8000, 32'd50, 32'd59, 32'h77, 32'd3, 32'd31,
                                  32'd12, 32'h7E8, 32'hD, 32'h1, 32'h5};

    initial begin
        int k;
        rst_i = 1'b1; start_i = 1'b0;
        set_fields();
        tick(3);
        check("rst_psel", PSEL, 0);       check("rst_penable", PENABLE, 0);
        check("rst_pwrite", PWRITE, 0);   check("rst_paddr", PADDR, 0);
        check("rst_pwdata", PWDATA, 0);   check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);     check("rst_err", err_o, 0);
        check("rst_code", err_code_o, 0);
        rst_i = 1'b0;
        tick(2);

        // Zero-wait run; inputs are scrambled after acceptance to prove shadowing.
        do_start();
        const_i = 32'hDEAD_BEEF; sec_i = 6'd0; hour_i = 5'd1; mode_i = 2'b00;
        check("t1_busy", busy_o, 1);        check("t1_setup_psel", PSEL, 1);
        check("t1_setup_pen", PENABLE, 0);  check("t1_setup_addr", PADDR, BASE + 32'h8);
        check("t1_setup_data", PWDATA, 32'h8000);
        wait_done(k);
        check("t1_done_lat", k, DONE_LAT);
        check("t1_err", err_o, 0);
        tick(1);
        check("t1_done_pulse", done_o, 0);  check("t1_busy_drop", busy_o, 0);
        check("t1_nxfer", n_xfer, N_XFER);  check("t1_stable", unstable, 0);
        for (int i = 0; i < 11; i++) begin
            check($sformatf("t1_addr%0d", i), log_addr[i], BASE + 32'(exp_off[i]));
            check($sformatf("t1_data%0d", i), log_data[i], exp_dat[i]);
            check($sformatf("t1_wr%0d", i), log_wr[i], 1);
        end
        set_fields();
        tick(2);

        // Three wait states on step 4 (INIT_DOW).
        wait_step = 4; wait_n = 3;
        do_start();
        wait_done(k);
        check("t2_done_lat", k, DONE_LAT + 3);
        check("t2_stable", unstable, 0);
        check("t2_addr4", log_addr[4], BASE + 32'h18);
        check("t2_data4", log_data[4], 32'd3);
        wait_step = -1; wait_n = 0;
        tick(3);

        // Slave error on step 2 (INIT_MIN).
        err_step = 2;
        do_start();
        wait_idle(k);
        check("t3_err_lat", k, 9);
        check("t3_err", err_o, 1);         check("t3_code", err_code_o, 1);
        check("t3_no_done", done_seen, 0); check("t3_nsetup", n_setup, 3);
        tick(5);
        check("t3_nsetup_later", n_setup, 3);
        check("t3_err_sticky", err_o, 1);
        err_step = -1;

        // Timeout with PREADY held low.
        hang = 1'b1;
        do_start();
        check("t4_err_clear", err_o, 0);   check("t4_code_clear", err_code_o, 0);
        tick(16);
        check("t4_access16", PENABLE, 1);  check("t4_no_err_yet", err_o, 0);
        tick(1);
        check("t4_psel_drop", PSEL, 0);    check("t4_penable_drop", PENABLE, 0);
        check("t4_err", err_o, 1);         check("t4_code", err_code_o, 2);
        check("t4_busy_in_err", busy_o, 1);
        tick(1);
        check("t4_busy_drop", busy_o, 0);
        hang = 1'b0;
        tick(2);

        // Start while busy is ignored; async reset mid-ACCESS; clean rerun.
        do_start();
        tick(15);
        check("t5_step5_setup", PADDR, BASE + 32'h1C);
        start_i = 1'b1;
        tick(1);
        start_i = 1'b0;
        check("t5_step5_access", PENABLE, 1);
        check("t5_nxfer5", n_xfer, 5);
        tick(2);
        check("t5_step6_addr", PADDR, BASE + 32'h20);
        tick(1);
        check("t5_step6_access", PENABLE, 1);
        rst_i = 1'b1;
        #1;
        check("t5_rst_psel", PSEL, 0);     check("t5_rst_penable", PENABLE, 0);
        check("t5_rst_busy", busy_o, 0);   check("t5_rst_paddr", PADDR, 0);
        tick(1);
        rst_i = 1'b0;
        tick(1);
        do_start();
        check("t5_rerun_addr0", PADDR, BASE + 32'h8);
        wait_done(k);
        check("t5_rerun_lat", k, DONE_LAT);
        check("t5_rerun_nxfer", n_xfer, N_XFER);
        tick(2);

`ifdef RTC_BOOT_READBACK_EN
        // Corrupted INIT_YEAR read-back.
        corrupt = 1'b1;
        do_start();
        wait_idle(k);
        check("rb_err_lat", k, 57);
        check("rb_err", err_o, 1);         check("rb_code", err_code_o, 3);
        check("rb_no_done", done_seen, 0); check("rb_nxfer", n_xfer, 19);
        corrupt = 1'b0;
        tick(2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
